dff_bank_write_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (the shared register) between NUM_REQ requesters. Each requester raises a write request with its data. The block picks one winner, loads its data into the register, and returns a one-cycle grant pulse. It sits between independent producer blocks and a single shared state register, and also keeps a saturating count of committed writes.

---
 rtl/dff_bank_write_arbiter.sv | 133 +++++++++++++
 tb/tb_dff_bank_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_write_arbiter.sv
// dff_bank_write_arbiter
// Round-robin arbiter that shares one WIDTH-bit register between NUM_REQ
// requesters. Each arbitration commits the winner's data to q, records the
// winner in owner, pulses grant for one cycle and bumps a saturating count
// of committed writes. Every write is followed by one ACK cycle, so the
// sustained rate is at most one write every two cycles.
module dff_bank_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         grant,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [CNT_W-1:0]           wr_count
);

    localparam int                 IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;

    // Pointer to the most recent winner; the search starts just after it.
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             found;

    // Per-requester view of the packed write data.
    logic [WIDTH-1:0] slice [NUM_REQ];

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Modulo-NUM_REQ increment, so indices >= NUM_REQ are never produced
    // even when NUM_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = wdata[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first requester after rr_ptr, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_inc(cand);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state logic: arbitrate only from IDLE, ACK always returns to IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shared register, owner, grant pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            owner  <= '0;
            grant  <= '0;
            rr_ptr <= LAST_IDX;
        end else begin
            grant <= '0;
            if (load) begin
                q      <= slice[winner];
                owner  <= winner;
                rr_ptr <= winner;
                grant  <= ONE_HOT0 << winner;
            end
        end
    end

    // Committed-write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (load) begin
            wr_count <= sat_inc(wr_count);
        end
    end

    assign busy = (state == ACK);

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Self-checking bench for dff_bank_write_arbiter: directed scenarios plus a
// randomized request stream compared against a behavioural model.
module tb_dff_bank_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default counter width)
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       grant;
    logic [WIDTH-1:0]         q;
    logic [IDX_W-1:0]         owner;
    logic                     busy;
    logic [CNT_W-1:0]         wr_count;

    // Second instance with a 4-bit counter for saturation
    logic                     reset_s;
    logic [NUM_REQ-1:0]       req_s;
    logic [NUM_REQ*WIDTH-1:0] wdata_s;
    logic [NUM_REQ-1:0]       grant_s;
    logic [WIDTH-1:0]         q_s;
    logic [IDX_W-1:0]         owner_s;
    logic                     busy_s;
    logic [3:0]               wr_count_s;

    dff_bank_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .grant(grant),
        .q(q), .owner(owner), .busy(busy), .wr_count(wr_count)
    );

    dff_bank_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset_s), .req(req_s), .wdata(wdata_s), .grant(grant_s),
        .q(q_s), .owner(owner_s), .busy(busy_s), .wr_count(wr_count_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the main instance
    int                 m_ptr;
    int                 m_owner;
    int                 m_cnt;
    logic [WIDTH-1:0]   m_q;
    logic [NUM_REQ-1:0] m_grant;
    bit                 m_busy;

    task automatic model_edge();
        int w;
        if (reset) begin
            m_q = '0; m_grant = '0; m_owner = 0; m_busy = 0; m_cnt = 0; m_ptr = NUM_REQ - 1;
        end else if (m_busy) begin
            m_busy = 0; m_grant = '0;
        end else begin
            m_grant = '0;
            if (req != '0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
                m_q     = wdata[w*WIDTH +: WIDTH];
                m_owner = w;
                m_ptr   = w;
                m_grant = NUM_REQ'(1 << w);
                m_cnt   = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
                m_busy  = 1;
            end
        end
    endtask

    // One rising edge; model advances on the same sampled inputs; outputs settle by #1
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; reset_s = 1'b1; req_s = '0;
        tick();
        reset = 1'b0; reset_s = 1'b0;
        n_checks++; if (q !== 8'h00) $display("FAIL reset_q got %h want 00", q); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant); else n_pass++;
        n_checks++; if (owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", owner); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (wr_count !== 8'd0) $display("FAIL reset_count got %0d want 0", wr_count); else n_pass++;
    endtask

    task automatic test_single();
        wdata = {8'h5A, 8'hA5, 8'h77, 8'h66};
        req   = 4'b0100;
        tick();
        req = '0;
        n_checks++; if (q !== 8'hA5) $display("FAIL single_q got %h want a5", q); else n_pass++;
        n_checks++; if (grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", grant); else n_pass++;
        n_checks++; if (owner !== 2'd2) $display("FAIL single_owner got %0d want 2", owner); else n_pass++;
        n_checks++; if (wr_count !== 8'd1) $display("FAIL single_count got %0d want 1", wr_count); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL single_grant_drop got %b want 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_drop got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] eg;
        logic [WIDTH-1:0]   eq;
        int                 idx;
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        eq    = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 2 == 0) begin
                idx = (i / 2) % NUM_REQ;
                eg  = NUM_REQ'(1 << idx);
                eq  = WIDTH'((idx + 1) * 17);
            end else begin
                eg = '0;
            end
            n_checks++; if (grant !== eg) $display("FAIL rr_grant cyc %0d got %b want %b", i, grant, eg); else n_pass++;
            n_checks++; if (q !== eq) $display("FAIL rr_q cyc %0d got %h want %h", i, q, eq); else n_pass++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_fairness();
        int exp_w [7] = '{2, 0, 2, 0, 1, 2, 0};
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req   = 4'b0001;
        tick();
        req = '0;
        tick();
        n_checks++; if (owner !== 2'd0) $display("FAIL fair_setup_owner got %0d want 0", owner); else n_pass++;
        req = 4'b0101;
        for (int j = 0; j < 7; j++) begin
            if (j == 4) req[1] = 1'b1;
            tick();
            n_checks++;
            if (grant !== NUM_REQ'(1 << exp_w[j])) $display("FAIL fair_grant step %0d got %b want %b", j, grant, NUM_REQ'(1 << exp_w[j]));
            else n_pass++;
            n_checks++;
            if (q !== wdata[exp_w[j]*WIDTH +: WIDTH]) $display("FAIL fair_q step %0d got %h want %h", j, q, wdata[exp_w[j]*WIDTH +: WIDTH]);
            else n_pass++;
            if (grant[1]) req[1] = 1'b0;
            tick();
            n_checks++; if (grant !== 4'b0000) $display("FAIL fair_gap step %0d got %b want 0000", j, grant); else n_pass++;
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        wdata = {8'h9E, 8'h12, 8'h34, 8'h56};
        req   = 4'b1000;
        tick();
        n_checks++; if (grant !== 4'b1000) $display("FAIL mid_grant3 got %b want 1000", grant); else n_pass++;
        reset = 1'b1;
        req   = 4'b1001;
        tick();
        reset = 1'b0;
        n_checks++; if (q !== 8'h00) $display("FAIL mid_q got %h want 00", q); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("FAIL mid_grant got %b want 0000", grant); else n_pass++;
        n_checks++; if (owner !== 2'd0) $display("FAIL mid_owner got %0d want 0", owner); else n_pass++;
        n_checks++; if (wr_count !== 8'd0) $display("FAIL mid_count got %0d want 0", wr_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0001) $display("FAIL mid_regrant got %b want 0001", grant); else n_pass++;
        n_checks++; if (q !== 8'h56) $display("FAIL mid_regrant_q got %h want 56", q); else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_idle_hold();
        int cnt_after;
        req = '0;
        tick();
        tick();
        wdata[15:8] = 8'h3C;
        req = 4'b0010;
        tick();
        req = '0;
        cnt_after = m_cnt;
        n_checks++; if (q !== 8'h3C) $display("FAIL idle_write_q got %h want 3c", q); else n_pass++;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_checks++; if (q !== 8'h3C) $display("FAIL idle_q cyc %0d got %h want 3c", i, q); else n_pass++;
            n_checks++; if (grant !== 4'b0000) $display("FAIL idle_grant cyc %0d got %b want 0000", i, grant); else n_pass++;
            n_checks++; if (wr_count !== CNT_W'(cnt_after)) $display("FAIL idle_count cyc %0d got %0d want %0d", i, wr_count, cnt_after); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int               exp_cnt;
        logic [WIDTH-1:0] d;
        reset_s = 1'b1; req_s = '0; wdata_s = '0;
        tick();
        reset_s = 1'b0;
        n_checks++; if (wr_count_s !== 4'd0) $display("FAIL sat_reset got %0d want 0", wr_count_s); else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            d = WIDTH'(k * 13);
            wdata_s[15:8] = d;
            req_s = 4'b0010;
            tick();
            exp_cnt = (k > 15) ? 15 : k;
            n_checks++; if (grant_s !== 4'b0010) $display("FAIL sat_grant write %0d got %b want 0010", k, grant_s); else n_pass++;
            n_checks++; if (wr_count_s !== 4'(exp_cnt)) $display("FAIL sat_count write %0d got %0d want %0d", k, wr_count_s, exp_cnt); else n_pass++;
            n_checks++; if (q_s !== d) $display("FAIL sat_q write %0d got %h want %h", k, q_s, d); else n_pass++;
            tick();
        end
        req_s = '0;
    endtask

    task automatic test_random();
        int                 waits [NUM_REQ];
        logic [NUM_REQ-1:0] prev_grant;
        bit                 inv_ok;
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        prev_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req[i] = 1'b1;
                        wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            tick();
            n_checks++; if (q !== m_q) $display("FAIL rnd_q cyc %0d got %h want %h", c, q, m_q); else n_pass++;
            n_checks++; if (grant !== m_grant) $display("FAIL rnd_grant cyc %0d got %b want %b", c, grant, m_grant); else n_pass++;
            n_checks++; if (owner !== IDX_W'(m_owner)) $display("FAIL rnd_owner cyc %0d got %0d want %0d", c, owner, m_owner); else n_pass++;
            n_checks++; if (busy !== m_busy) $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, m_busy); else n_pass++;
            n_checks++; if (wr_count !== CNT_W'(m_cnt)) $display("FAIL rnd_count cyc %0d got %0d want %0d", c, wr_count, m_cnt); else n_pass++;
            inv_ok = (grant === '0) || ($onehot(grant) && prev_grant === '0);
            n_checks++; if (!inv_ok) $display("FAIL rnd_grant_shape cyc %0d got %b prev %b want one-hot after idle", c, grant, prev_grant); else n_pass++;
            if (grant !== '0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) waits[i] = 0;
                    else if (req[i]) waits[i]++;
                    n_checks++;
                    if (waits[i] > NUM_REQ - 1) $display("FAIL rnd_fairness req %0d got %0d waits want <= %0d", i, waits[i], NUM_REQ - 1);
                    else n_pass++;
                end
            end
            prev_grant = grant;
        end
        req = '0;
    endtask

    initial begin
        reset = 1'b1; req = '0; wdata = '0;
        reset_s = 1'b1; req_s = '0; wdata_s = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid();
        test_idle_hold();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
